// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data, memory and status signals of
// mem_port_arbiter.
//   slave  modport : arbiter side (requests/memory response in, acks/memory
//                    request/stalls/error out)
//   master modport : environment side (requesters and memory model)
// With MEM_ARB_STATS_EN defined, the 16-bit statistics outputs are added.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  dm_ren;
  logic                  dm_wen;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  stall_if;
  logic                  stall_mem;
  logic                  bus_err;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]           stat_if_grants;
  logic [15:0]           stat_dm_grants;
  logic [15:0]           stat_wait;
`endif

  modport slave (
    input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, bus_err
`ifdef MEM_ARB_STATS_EN
    , output stat_if_grants, stat_dm_grants, stat_wait
`endif
  );

  modport master (
    output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, bus_err
`ifdef MEM_ARB_STATS_EN
    , input stat_if_grants, stat_dm_grants, stat_wait
`endif
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access, one transaction at a time, with fetch starvation
// protection and a memory-timeout watchdog.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - mem_port_arbiter_if.slave: fetch request/ack/rdata, data
//          read/write request/ack/rdata, memory req/we/addr/wdata/rdata/ack,
//          stall_if/stall_mem (combinational), sticky bus_err
// Optional feature macro: MEM_ARB_STATS_EN adds saturating 16-bit counters
// stat_if_grants, stat_dm_grants and stat_wait on the interface.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;   // consecutive data grants while fetch waited
  logic [WD_W-1:0]     wd;       // BUSY cycles elapsed minus one
  logic                dm_pend;
  logic                dm_win;
  logic                timeout_hit;

  // Data wins unless fetch is waiting and data already had its quota.
  assign dm_pend     = bus.dm_ren | bus.dm_wen;
  assign dm_win      = dm_pend & (~bus.if_req | (streak < STREAK_MAX));
  assign timeout_hit = (wd == WD_LAST);

  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = dm_pend & ~bus.dm_ack;

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      streak        <= '0;
      wd            <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= ADDR_WIDTH'(0);
      bus.mem_wdata <= DATA_WIDTH'(0);
      bus.if_rdata  <= DATA_WIDTH'(0);
      bus.dm_rdata  <= DATA_WIDTH'(0);
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          if (dm_win) begin
            state         <= BUSY_DM;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_wen;  // read+write together is a write
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            streak        <= bus.if_req ? streak + STREAK_W'(1) : '0;
          end else if (bus.if_req) begin
            state         <= BUSY_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= DATA_WIDTH'(0);
            streak        <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (bus.mem_ack || timeout_hit) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            wd          <= '0;
            if (!bus.mem_ack) begin
              bus.bus_err <= 1'b1;
            end
            if (state == BUSY_IF) begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : DATA_WIDTH'(0);
            end else begin
              bus.dm_ack   <= 1'b1;
              bus.dm_rdata <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata
                                                            : DATA_WIDTH'(0);
            end
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DONE: begin
          bus.if_ack <= 1'b0;
          bus.dm_ack <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating grant and stall-cycle counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.stat_if_grants <= 16'd0;
      bus.stat_dm_grants <= 16'd0;
      bus.stat_wait      <= 16'd0;
    end else begin
      if (state == IDLE && dm_win && bus.stat_dm_grants != 16'hFFFF) begin
        bus.stat_dm_grants <= bus.stat_dm_grants + 16'd1;
      end
      if (state == IDLE && !dm_win && bus.if_req && bus.stat_if_grants != 16'hFFFF) begin
        bus.stat_if_grants <= bus.stat_if_grants + 16'd1;
      end
      if ((bus.stall_if || bus.stall_mem) && bus.stat_wait != 16'hFFFF) begin
        bus.stat_wait <= bus.stat_wait + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter.
// A transaction-level model predicts grant order, memory-side timing,
// requester acks/read data and the sticky error flag; the bench also plays
// the memory (random latency, stray acks, never-ack for timeouts).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          SL = 4;
  localparam int          TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Requester state: held until acked.
  bit          p_if, p_r, p_w;
  logic [31:0] a_if, a_dm, wd_dm;
  bit          pv_if, pv_dm;       // requests as driven during the previous cycle
  int          gmode;              // 0 none, 1 random, 2 always re-request
  int          lat_cfg;            // -1 random, 0 never ack, else fixed latency

  // Transaction-level model.
  int          c, t_free, t_done, bn, lat, streak;
  bit          busy, g_dm, done_dm, exp_we, err_m;
  logic [31:0] exp_addr, exp_wd, done_data;
  int          n_ifack, n_dmack, g_if_n, g_dm_n, wait_n;
  bit [31:0]   mem_m [bit [31:0]];

  function automatic logic [31:0] mem_read(input bit [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic drive();
    bus.if_req   = p_if;
    bus.if_addr  = a_if;
    bus.dm_ren   = p_r;
    bus.dm_wen   = p_w;
    bus.dm_addr  = a_dm;
    bus.dm_wdata = wd_dm;
  endtask

  task automatic new_if();
    p_if = 1'b1;
    a_if = 32'($urandom_range(0, 255)) << 2;
  endtask

  task automatic new_dm();
    int k;
    k     = int'($urandom_range(0, 2));
    p_r   = (k != 1);
    p_w   = (k != 0);
    a_dm  = 32'($urandom_range(0, 63)) << 2;
    wd_dm = $urandom;
  endtask

  task automatic gen();
    if (gmode == 1) begin
      if (!p_if && $urandom_range(0, 1) == 1) new_if();
      if (!(p_r || p_w) && $urandom_range(0, 1) == 1) new_dm();
    end else if (gmode == 2) begin
      if (!p_if) new_if();
      if (!(p_r || p_w)) new_dm();
    end
  endtask

  function automatic int pick_lat();
    if (lat_cfg >= 0) return lat_cfg;
    if ($urandom_range(0, 9) == 0) return 0;
    return int'($urandom_range(1, 4));
  endfunction

  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    p_if = 0; p_r = 0; p_w = 0;
    drive();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b1;
    c = 0; t_free = 0; t_done = -1; busy = 0; streak = 0; err_m = 0;
    pv_if = 0; pv_dm = 0; g_if_n = 0; g_dm_n = 0; wait_n = 0;
  endtask

  // One clock cycle: observe and check, answer as memory, drive requesters.
  task automatic eng_cycle();
    bit          ack_if_now, ack_dm_now, fin, ack_d, pdm;
    logic [31:0] rd_d;
    @(posedge clk);
    #1;
    c++;
    ack_if_now = (c == t_done) && !done_dm;
    ack_dm_now = (c == t_done) && done_dm;
    if (bus.if_ack === 1'b1) n_ifack++;
    if (bus.dm_ack === 1'b1) n_dmack++;

    if (c == t_done) begin
      check("done_mem_req", bus.mem_req, 1'b0);
      check("done_acks", {bus.if_ack, bus.dm_ack}, {ack_if_now, ack_dm_now});
      if (done_dm) begin
        check("dm_rdata", bus.dm_rdata, done_data);
        p_r = 0; p_w = 0;
      end else begin
        check("if_rdata", bus.if_rdata, done_data);
        p_if = 0;
      end
      check("bus_err", bus.bus_err, err_m);
    end else begin
      check("acks_quiet", {bus.if_ack, bus.dm_ack}, 2'b00);
    end

    fin = 0;
    if (!busy) begin
      if (c - 1 >= t_free && (pv_if || pv_dm)) begin
        g_dm   = pv_dm && (!pv_if || streak < SL);
        streak = g_dm ? (pv_if ? streak + 1 : 0) : 0;
        if (g_dm) g_dm_n++; else g_if_n++;
        exp_addr = g_dm ? a_dm : a_if;
        exp_we   = g_dm && p_w;
        exp_wd   = wd_dm;
        busy = 1; bn = 1; lat = pick_lat();
        check("grant_req", bus.mem_req, 1'b1);
        check("grant_addr", bus.mem_addr, exp_addr);
        check("grant_we", bus.mem_we, exp_we);
        if (exp_we) check("grant_wdata", bus.mem_wdata, exp_wd);
      end else begin
        check("idle_req", bus.mem_req, 1'b0);
      end
    end else begin
      bn++;
      check("busy_req", bus.mem_req, 1'b1);
      check("busy_addr", bus.mem_addr, exp_addr);
      check("busy_we", bus.mem_we, exp_we);
    end

    ack_d = 0;
    rd_d  = $urandom;
    if (busy) begin
      if (lat != 0 && bn == lat) begin
        ack_d = 1;
        if (exp_we) begin
          mem_m[exp_addr] = exp_wd;
          done_data = '0;
        end else begin
          rd_d = mem_read(exp_addr);
          done_data = rd_d;
        end
        fin = 1;
      end else if (bn == TO) begin
        done_data = '0;
        err_m = 1;
        fin = 1;
      end
    end else begin
      ack_d = ($urandom_range(0, 3) == 0);  // stray ack must be ignored
    end
    if (fin) begin
      busy = 0; t_done = c + 1; t_free = c + 2; done_dm = g_dm;
    end
    bus.mem_ack   = ack_d;
    bus.mem_rdata = rd_d;

    gen();
    drive();
    pdm   = p_r || p_w;
    pv_if = p_if;
    pv_dm = pdm;
    if ((p_if && !ack_if_now) || (pdm && !ack_dm_now)) wait_n++;
    #1;
    check("stall_if", bus.stall_if, p_if && !ack_if_now);
    check("stall_mem", bus.stall_mem, pdm && !ack_dm_now);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    gmode = 0;
    while ((p_if || p_r || p_w || busy || c < t_free) && n < budget) begin
      eng_cycle();
      n++;
    end
    check("drain", {p_if, p_r | p_w, busy}, 3'b000);
  endtask

  initial begin
    int n;
    gmode = 0; lat_cfg = 1;
    a_if = '0; a_dm = '0; wd_dm = '0;
    do_reset(3);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_acks", {bus.if_ack, bus.dm_ack}, 2'b00);
    check("rst_bus_err", bus.bus_err, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);

    // Single fetch, single-cycle memory.
    mem_m[32'h40] = 32'h2008_0005;
    lat_cfg = 1;
    p_if = 1; a_if = 32'h40;
    drain(20);
    check("fetch_rdata_0x40", bus.if_rdata, 32'h2008_0005);

    // Simultaneous fetch and data read: data first, fetch right after.
    n_ifack = 0; n_dmack = 0;
    p_if = 1; a_if = 32'h44; p_r = 1; a_dm = 32'h100;
    drain(20);
    check("simul_acks", {32'(n_ifack), 32'(n_dmack)}, {32'd1, 32'd1});

    // Continuous data traffic with fetch waiting.
    n_ifack = 0; n_dmack = 0; gmode = 2; n = 0;
    while (n_ifack < 3 && n < 300) begin
      eng_cycle();
      n++;
    end
    check("starve_dm_grants", 32'(n_dmack), 32'd12);
    drain(40);

    // Write, then read back, then read+write together.
    lat_cfg = 2;
    p_w = 1; a_dm = 32'h200; wd_dm = 32'hDEAD_BEEF;
    drain(20);
    check("write_dm_rdata", bus.dm_rdata, 32'h0);
    p_r = 1; a_dm = 32'h200;
    drain(20);
    check("readback_0x200", bus.dm_rdata, 32'hDEAD_BEEF);
    p_r = 1; p_w = 1; a_dm = 32'h204; wd_dm = 32'h1234_5678;
    drain(20);

    // Memory never answers.
    lat_cfg = 0;
    p_if = 1; a_if = 32'h80;
    drain(40);
    lat_cfg = 1;
    p_if = 1; a_if = 32'h84;
    drain(20);
    check("bus_err_sticky", bus.bus_err, 1'b1);

    // Reset in the middle of a data transaction.
    lat_cfg = 0;
    p_r = 1; a_dm = 32'h300;
    n = 0;
    while (!(busy && bn == 3) && n < 20) begin
      eng_cycle();
      n++;
    end
    check("pre_rst_mem_req", bus.mem_req, 1'b1);
    rst = 1'b0;
    p_if = 0; p_r = 0; p_w = 0;
    drive();
    bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_mem_req", bus.mem_req, 1'b0);
    check("mid_rst_mem_we", bus.mem_we, 1'b0);
    check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    check("mid_rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("mid_rst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
    check("mid_rst_acks", {bus.if_ack, bus.dm_ack}, 2'b00);
    check("mid_rst_bus_err", bus.bus_err, 1'b0);
    do_reset(1);

    // Random traffic with random latencies and occasional timeouts.
    lat_cfg = -1; gmode = 1;
    repeat (400) eng_cycle();
    drain(100);
    check("final_bus_err", bus.bus_err, err_m);

`ifdef MEM_ARB_STATS_EN
    @(posedge clk);
    #1;
    check("stat_if_grants", bus.stat_if_grants, 16'(g_if_n));
    check("stat_dm_grants", bus.stat_dm_grants, 16'(g_dm_n));
    check("stat_wait", bus.stat_wait, 16'(wait_n));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the MIPS pipeline. Grants one transaction at a time, drives the memory-side handshake, returns read data with a one-cycle acknowledge, and produces stall signals for the pipeline controller. Includes starvation protection for fetch and a memory-timeout watchdog.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data word width.
- `STARVE_LIMIT`, 4, consecutive data grants allowed while fetch waits (legal range ≥1).
- `TIMEOUT`, 15, maximum cycles from `mem_req` rise to `mem_ack` before abort (legal range ≥1).

Ports:
- `clk`  in  1  main clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_rdata`  out  DATA_WIDTH  fetched word, valid with `if_ack`.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `dm_ren`  in  1  data read request; held until `dm_ack`.
- `dm_wen`  in  1  data write request; held until `dm_ack`.
- `dm_addr`  in  ADDR_WIDTH  data address.
- `dm_wdata`  in  DATA_WIDTH  write data.
- `dm_rdata`  out  DATA_WIDTH  read data, valid with `dm_ack`.
- `dm_ack`  out  1  one-cycle data completion pulse.
- `mem_req`  out  1  memory request, held until `mem_ack` or timeout.
- `mem_we`  out  1  memory write enable, qualified by `mem_req`.
- `mem_addr`  out  ADDR_WIDTH  registered memory address.
- `mem_wdata`  out  DATA_WIDTH  registered write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle memory completion pulse.
- `stall_if`  out  1  `if_req & ~if_ack` (combinational).
- `stall_mem`  out  1  `(dm_ren | dm_wen) & ~dm_ack` (combinational).
- `bus_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE: if data request pending and (`if_req` low or `streak < STARVE_LIMIT`) → latch `dm_addr`/`dm_wdata`, `mem_we = dm_wen`, go BUSY_DM, increment `streak` if `if_req` high, else clear it. Else if `if_req` → latch `if_addr`, `mem_we = 0`, go BUSY_IF, clear `streak`. Else stay.
- `dm_ren` and `dm_wen` both high: performed as a write; single `dm_ack`; `dm_rdata` = 0.
- BUSY_x: `mem_req` high; on `mem_ack` capture `mem_rdata` into the granted requester's rdata register (writes capture 0), go DONE. Watchdog counts cycles in BUSY; at `TIMEOUT` without `mem_ack` → drop `mem_req`, set `bus_err`, rdata = 0, go DONE.
- DONE: pulse granted ack for exactly one cycle, `mem_req` low, return to IDLE. Next grant decision taken in IDLE the following cycle.
- `mem_ack` outside BUSY: ignored.
- Reset: state IDLE, `streak`/watchdog 0; all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, acks, `bus_err`). Reset mid-transaction aborts it with no ack.

## Timing
- Request sampled in IDLE at cycle 0; `mem_req` high from cycle 1; `mem_ack` at cycle k (k≥1); requester ack and rdata at cycle k+1; IDLE at k+2.
- Minimum turnaround: 3 cycles per transaction for k=1 (single-cycle memory).
- `mem_addr`/`mem_wdata`/`mem_we` stable for the whole BUSY period.
- Timeout: `mem_req` deasserted the cycle after the TIMEOUT-th BUSY cycle; ack one cycle later.
- Requester changing address while waiting: not supported; latched value used.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds outputs `stat_if_grants`, `stat_dm_grants` (16-bit, counted at grant), `stat_wait` (16-bit, cycles with `stall_if | stall_mem`); all saturate at 0xFFFF, reset to 0.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Test plan
- Fetch only, `if_addr`=0x0000_0040, memory acks after 1 cycle with 0x2008_0005 → `mem_req` cycles 1–1, `if_ack` + `if_rdata`=0x2008_0005 at cycle 2.
- Simultaneous `if_req` and `dm_ren` at 0x100 → data granted first, `dm_ack` precedes `if_ack`; fetch issued immediately after.
- Data requests continuous with fetch waiting, STARVE_LIMIT=4 → exactly 4 data grants then 1 fetch grant, repeating.
- `dm_wen`=1, `dm_wdata`=0xDEAD_BEEF, addr 0x200 → `mem_we`=1, `mem_wdata`=0xDEAD_BEEF, `dm_ack` pulse, `dm_rdata`=0.
- Memory never acks, TIMEOUT=15 → `mem_req` drops after 15 BUSY cycles, `bus_err`=1 sticky, requester acked with rdata 0.
- `rst` low during BUSY_DM → next cycle IDLE, all outputs 0, no `dm_ack`; `bus_err` cleared.
